// File: rtl/uart_tx_v2_0.sv
// uart_tx_v2_0: multi-byte UART transmitter with runtime divisor, 5-8 data bits, parity and 1/2 stop bits
module uart_tx_v2_0 #(
  parameter int P_MAX_BYTES    = 4,
  parameter int P_NBYTES_WIDTH = 3,
  parameter int P_DIV_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*P_MAX_BYTES-1:0]   ip_data,
  input  logic [P_NBYTES_WIDTH-1:0]  ip_nbytes,
  input  logic [P_DIV_WIDTH-1:0]     ip_baud_div,
  input  logic [1:0]                 ip_data_bits,
  input  logic [1:0]                 ip_parity,
  input  logic                       i_stop2,
  input  logic                       i_data_valid,
  output logic                       o_data_ready,
  output logic                       o_busy,
  output logic                       or_tx,
  output logic                       o_frame_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic go_q, go_d, stop_q, stop_d, stop2_q, stop2_d, tx_q, tx_d, done_q, done_d;
  logic [P_DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0] bit_q, bit_d, nxt;
  logic [P_NBYTES_WIDTH-1:0] byte_q, byte_d, nb_clamp;
  logic [8*P_MAX_BYTES-1:0] data_q, data_d;
  logic [1:0] nbits_q, nbits_d, par_q, par_d;
  logic tick, last_bit, par_bit;
  logic [7:0] cur, mask;
  assign nb_clamp = (ip_nbytes == '0) ? P_NBYTES_WIDTH'(1) :
                    (ip_nbytes > P_NBYTES_WIDTH'(P_MAX_BYTES)) ? P_NBYTES_WIDTH'(P_MAX_BYTES) : ip_nbytes;
  assign cur      = 8'(data_q >> (32'(byte_q) * 8));
  assign mask     = 8'hFF >> (2'd3 - nbits_q);
  assign par_bit  = (par_q == 2'b01) ? ~^(cur & mask) : ^(cur & mask);
  assign tick     = cnt_q == div_q;
  assign last_bit = bit_q == ({1'b0, nbits_q} + 3'd4);
  assign nxt      = bit_q + 3'd1;
  assign o_data_ready = state_q == IDLE;
  assign o_busy       = state_q != IDLE;
  assign or_tx        = tx_q;
  assign o_frame_done = done_q;
  // Acceptance only arms go_q; START follows one edge later so line and busy move together
  always_comb begin
    state_d = state_q;
    go_d    = go_q;
    stop_d  = stop_q;
    stop2_d = stop2_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    data_d  = data_q;
    nbits_d = nbits_q;
    par_d   = par_q;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        go_d = 1'b0;
        if (go_q) begin
          state_d = START;
          tx_d    = 1'b0;
        end else if (i_data_valid) begin
          go_d    = 1'b1;
          data_d  = ip_data;
          byte_d  = nb_clamp - 1'b1;
          div_d   = ip_baud_div;
          nbits_d = ip_data_bits;
          par_d   = ip_parity;
          stop2_d = i_stop2;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = cur[0];
      end
      DATA: if (tick) begin
        if (!last_bit) begin
          bit_d = nxt;
          tx_d  = cur[nxt];
        end else if (^par_q) begin
          state_d = PARITY;
          tx_d    = par_bit;
        end else begin
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      PARITY: if (tick) begin
        state_d = STOP;
        stop_d  = 1'b0;
        tx_d    = 1'b1;
      end
      STOP: if (tick) begin
        if (stop2_q && !stop_q) begin
          stop_d = 1'b1;
        end else if (byte_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = START;
          byte_d  = byte_q - 1'b1;
          tx_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      stop_q  <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      nbits_q <= '0;
      par_q   <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      stop_q  <= stop_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      nbits_q <= nbits_d;
      par_q   <= par_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_v2_0.sv
// tb_uart_tx_v2_0: scoreboard bench; stimulus queues expected bytes, a line monitor decodes or_tx and compares
module tb_uart_tx_v2_0;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] ip_data = '0;
  logic [2:0] ip_nbytes = '0;
  logic [15:0] ip_baud_div = '0;
  logic [1:0] ip_data_bits = '0, ip_parity = '0;
  logic i_stop2 = 1'b0, i_data_valid = 1'b0;
  logic o_data_ready, o_busy, or_tx, o_frame_done;
  always #5 clk = ~clk;

  uart_tx_v2_0 #(.P_MAX_BYTES(4), .P_NBYTES_WIDTH(3), .P_DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .ip_data(ip_data), .ip_nbytes(ip_nbytes), .ip_baud_div(ip_baud_div),
    .ip_data_bits(ip_data_bits), .ip_parity(ip_parity), .i_stop2(i_stop2), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .o_busy(o_busy), .or_tx(or_tx), .o_frame_done(o_frame_done));

  typedef struct {logic [7:0] b; int n; bit pe; logic pb; int s; int div; bit last; bit abrt;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit mon_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(logic [7:0] b, int n, bit pe, logic pb, int s, int div, bit last, bit abrt = 1'b0);
    exp_t e;
    e.b = b; e.n = n; e.pe = pe; e.pb = pb; e.s = s; e.div = div; e.last = last; e.abrt = abrt;
    return e;
  endfunction

  // Monitor: on a start bit, pop the expected byte and check every cycle of every bit
  initial begin : monitor
    exp_t e;
    logic [11:0] eb;
    int tot;
    bit bad, cut, more;
    forever begin
      @(negedge clk);
      if (rst || or_tx !== 1'b0) continue;
      if (q.size() == 0) begin
        chk("unexpected_start", 32'd1, 32'd0);
        while (!rst && or_tx === 1'b0) @(negedge clk);
        continue;
      end
      mon_busy = 1'b1;
      more = 1'b1;
      while (more) begin
        e = q.pop_front();
        eb = '1;
        eb[0] = 1'b0;
        for (int j = 0; j < e.n; j++) eb[1+j] = e.b[j];
        if (e.pe) eb[1+e.n] = e.pb;
        tot = (1 + e.n + int'(e.pe) + e.s) * (e.div + 1);
        bad = 1'b0;
        cut = 1'b0;
        for (int k = 0; k < tot; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            cut = 1'b1;
            break;
          end
          if (or_tx !== eb[k/(e.div+1)] || o_frame_done !== 1'b0) bad = 1'b1;
        end
        chk("reset_cut", 32'(cut), 32'(e.abrt));
        if (cut) more = 1'b0;
        else begin
          chk($sformatf("byte_%02h_line", e.b), 32'(bad), 32'd0);
          @(negedge clk);
          if (e.last) begin
            chk("frame_done_ready", {30'd0, o_frame_done, o_data_ready}, 32'd3);
            more = 1'b0;
          end else begin
            chk("no_gap_start", {31'd0, or_tx}, 32'd0);
            if (or_tx !== 1'b0 || q.size() == 0 || rst) more = 1'b0;
          end
        end
      end
      mon_busy = 1'b0;
    end
  end

  task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic [15:0] div,
                      input logic [1:0] bits, input logic [1:0] par, input logic s2);
    int k = 0;
    @(negedge clk);
    while (!o_data_ready && k < 20000) begin
      @(negedge clk);
      k++;
    end
    ip_data = d; ip_nbytes = nb; ip_baud_div = div; ip_data_bits = bits; ip_parity = par; i_stop2 = s2;
    i_data_valid = 1'b1;
    @(posedge clk);
    #1;
    i_data_valid = 1'b0;
    ip_data = ~d; ip_nbytes = nb ^ 3'b101; ip_baud_div = div + 16'd3;
    ip_data_bits = ~bits; ip_parity = ~par; i_stop2 = ~s2;
    @(negedge clk);
    chk("accept_lag", {29'd0, o_busy, o_data_ready, or_tx}, 32'b011);
    @(negedge clk);
    chk("start_busy", {29'd0, o_busy, o_data_ready, or_tx}, 32'b100);
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || mon_busy) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", 32'(k < 20000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    int k, fd;
    i_data_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {28'd0, or_tx, o_data_ready, o_busy, o_frame_done}, 32'b1100);
    i_data_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {28'd0, or_tx, o_data_ready, o_busy, o_frame_done}, 32'b1100);

    q.push_back(mk(8'h55, 8, 0, 0, 1, 9, 1));
    send(32'h55, 3'd1, 16'd9, 2'd3, 2'b00, 1'b0);
    drain();

    q.push_back(mk(8'hA5, 8, 1, 1'b0, 1, 3, 1));
    send(32'hA5, 3'd1, 16'd3, 2'd3, 2'b10, 1'b0);
    drain();
    q.push_back(mk(8'hA5, 8, 1, 1'b1, 1, 3, 1));
    send(32'hA5, 3'd1, 16'd3, 2'd3, 2'b01, 1'b0);
    drain();
    q.push_back(mk(8'hA5, 8, 0, 1'b0, 1, 3, 1));
    send(32'hA5, 3'd1, 16'd3, 2'd3, 2'b11, 1'b0);
    drain();

    q.push_back(mk(8'hFF, 5, 0, 0, 2, 1, 1));
    send(32'hFF, 3'd1, 16'd1, 2'd0, 2'b00, 1'b1);
    drain();

    q.push_back(mk(8'h12, 8, 0, 0, 1, 0, 0));
    q.push_back(mk(8'h34, 8, 0, 0, 1, 0, 0));
    q.push_back(mk(8'h56, 8, 0, 0, 1, 0, 1));
    send(32'h00123456, 3'd3, 16'd0, 2'd3, 2'b00, 1'b0);
    drain();
    q.push_back(mk(8'h56, 8, 0, 0, 1, 0, 1));
    send(32'h00123456, 3'd0, 16'd0, 2'd3, 2'b00, 1'b0);
    drain();
    q.push_back(mk(8'h00, 8, 0, 0, 1, 0, 0));
    q.push_back(mk(8'h12, 8, 0, 0, 1, 0, 0));
    q.push_back(mk(8'h34, 8, 0, 0, 1, 0, 0));
    q.push_back(mk(8'h56, 8, 0, 0, 1, 0, 1));
    send(32'h00123456, 3'd7, 16'd0, 2'd3, 2'b00, 1'b0);
    drain();

    // Back-to-back: valid stays high; the second frame's inputs appear while the first is on the line
    @(negedge clk);
    q.push_back(mk(8'h3C, 8, 0, 0, 1, 2, 1));
    ip_data = 32'h3C; ip_nbytes = 3'd1; ip_baud_div = 16'd2; ip_data_bits = 2'd3; ip_parity = 2'b00; i_stop2 = 1'b0;
    i_data_valid = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(mk(8'h80, 7, 1, 1'b0, 2, 1, 0));
    q.push_back(mk(8'hC3, 7, 1, 1'b1, 2, 1, 1));
    ip_data = 32'h80C3; ip_nbytes = 3'd2; ip_baud_div = 16'd1; ip_data_bits = 2'd2; ip_parity = 2'b10; i_stop2 = 1'b1;
    k = 0;
    while (o_frame_done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done_seen", 32'(k < 2000), 32'd1);
    @(posedge clk);
    #1;
    i_data_valid = 1'b0;
    @(negedge clk);
    chk("b2b_pending", {29'd0, or_tx, o_frame_done, o_busy}, 32'b100);
    @(negedge clk);
    chk("b2b_start", {30'd0, or_tx, o_busy}, 32'b01);
    drain();

    q.push_back(mk(8'h55, 8, 0, 0, 1, 3, 1, 1));
    send(32'h55, 3'd1, 16'd3, 2'd3, 2'b00, 1'b0);
    repeat (16) @(posedge clk);
    #2;
    chk("pre_rst_line", {31'd0, or_tx}, 32'd0);
    rst = 1'b1;
    i_data_valid = 1'b1;
    #1;
    chk("async_rst_tx", {31'd0, or_tx}, 32'd1);
    repeat (2) @(negedge clk);
    chk("rst_hold", {30'd0, o_busy, o_data_ready}, 32'b01);
    rst = 1'b0;
    i_data_valid = 1'b0;
    @(negedge clk);
    chk("rst_release", {29'd0, o_busy, o_data_ready, or_tx}, 32'b011);
    fd = 0;
    repeat (40) begin
      @(negedge clk);
      fd |= int'(o_frame_done);
    end
    chk("no_done_after_rst", 32'(fd), 32'd0);
    drain();

    q.push_back(mk(8'h3B, 6, 1, 1'b0, 1, 2, 1));
    send(32'h3B, 3'd1, 16'd2, 2'd1, 2'b01, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
